gc_stream_rx: RTL
=================

GC_STREAM_RX -- requirements
Module: gc_stream_rx

Interface
REQ-001 Parameter S, 20, index/address width.
REQ-002 Parameter K, 128, label and key width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tag  input  3  stream tag: 000 idle, 001 keys, 010 garbled table, 011 masks, 101 input0, 110 input1, 111 input0+1, 100 illegal.
REQ-006 index0, index1  input  S each  stream indices.
REQ-007 data0, data1  input  K each  stream payloads.
REQ-008 R, aes_key  output  K each  captured global offset and AES key.
REQ-009 keys_valid  output  1  high once keys captured.
REQ-010 il_wr_en0, il_wr_en1  output  1 each  input-label memory write strobes.
REQ-011 il_wr_addr0, il_wr_addr1  output  S each  input-label write addresses.
REQ-012 il_wr_data0, il_wr_data1  output  K each  input-label write data.
REQ-013 gt_wr_en  output  1  garbled-table pair write strobe (both words).
REQ-014 gt_wr_addr0, gt_wr_addr1  output  S each  table word addresses.
REQ-015 gt_wr_data0, gt_wr_data1  output  K each  table word data.
REQ-016 gt_cnt  output  S  garbled-table pairs accepted.
REQ-017 lbl_cnt  output  S  input labels accepted (per label, not per beat).
REQ-018 mask  output  2K  output masks; bit 0 = data0[K-1], bit 2K-1 = data1[0] (MSB-first concatenation data0,data1 reversed to ascending output index).
REQ-019 done, err  output  1 each  stream complete; sticky error.
REQ-020 err_code  output  2  01 tag out of sequence, 10 table index out of order, 11 illegal tag 100.

Function
REQ-021 States IDLE, RECV, DONE, ERROR; reset enters IDLE.
REQ-022 IDLE: tag 001 -> capture R=data0, aes_key=data1, keys_valid=1, go RECV; tag 000 stays; any other tag -> ERROR.
REQ-023 IDLE keys beat with data0[0]=0 -> ERROR, code 01 (R LSB must be 1).
REQ-024 RECV tag 1xx (x!=00): for each set bit tag[0]/tag[1], assert il_wr_enN with addr indexN, data dataN; lbl_cnt += number of set bits.
REQ-025 RECV tag 010: require index0 == 2*gt_cnt and index1 == index0+1 (mod 2^S), else ERROR code 10; on pass, gt_wr_en=1, addresses/data = index/data, gt_cnt += 1.
REQ-026 RECV tag 011: mask <= reversed {data0,data1}, done=1, go DONE.
REQ-027 RECV tag 001 -> ERROR code 01; tag 100 in any state -> ERROR code 11; tag 000 -> no action.
REQ-028 DONE: repeated 011 beats ignored (mask unchanged); 000 ignored; any other tag -> ERROR code 01.
REQ-029 ERROR: all write strobes low, all captured values/counters frozen, err=1, err_code holds first error; exit only via rst.
REQ-030 All memory write outputs registered: strobe/addr/data appear exactly one cycle after the accepting beat, strobes high for one cycle.
REQ-031 Counters and keys_valid/done/err update on the same edge as the registered write outputs.
REQ-032 Index check uses pre-increment gt_cnt; gt_cnt and lbl_cnt wrap modulo 2^S.
REQ-033 Beat causing an error produces no write strobe.

Reset
REQ-034 rst sampled high at any edge, including mid-stream: state IDLE, R=0, aes_key=0, mask=0, gt_cnt=0, lbl_cnt=0, all strobes 0, addresses and data 0, keys_valid=done=err=0, err_code=00.

Verification
REQ-035 Keys: tag 001, data0=0x...01, data1=0xA5..A5 -> next cycle R/aes_key equal inputs, keys_valid=1, state RECV.
REQ-036 Labels: tag 111 idx 0/1, then 101 idx 5 -> il_wr_en0/1 both one cycle then en0 only at addr 5; lbl_cnt=3.
REQ-037 Tables: tag 010 idx (0,1),(2,3),(4,5) -> three gt_wr_en pulses, gt_cnt=3; then idx (8,9) -> err=1, err_code=10, no strobe, gt_cnt stays 3.
REQ-038 Masks: tag 011 data0 MSB=1, rest 0 -> mask[0]=1, done=1; second 011 with different data -> mask unchanged; following 010 -> err_code=01.
REQ-039 Sequence errors: 010 in IDLE -> err_code=01; tag 100 in RECV -> err_code=11; later beats no effect.
REQ-040 Reset mid-RECV after 2 tables: rst one cycle -> all outputs zero next cycle; fresh 001 accepted normally.

Source files
------------

// File: rtl/gc_stream_rx.sv
// Garbled-circuit stream receiver: decodes tagged beats into key capture,
// input-label and garbled-table memory writes, and output masks.
module gc_stream_rx #(
  parameter int S = 20,
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     tag,
  input  logic [S-1:0]   index0,
  input  logic [S-1:0]   index1,
  input  logic [K-1:0]   data0,
  input  logic [K-1:0]   data1,
  output logic [K-1:0]   R,
  output logic [K-1:0]   aes_key,
  output logic           keys_valid,
  output logic           il_wr_en0,
  output logic           il_wr_en1,
  output logic [S-1:0]   il_wr_addr0,
  output logic [S-1:0]   il_wr_addr1,
  output logic [K-1:0]   il_wr_data0,
  output logic [K-1:0]   il_wr_data1,
  output logic           gt_wr_en,
  output logic [S-1:0]   gt_wr_addr0,
  output logic [S-1:0]   gt_wr_addr1,
  output logic [K-1:0]   gt_wr_data0,
  output logic [K-1:0]   gt_wr_data1,
  output logic [S-1:0]   gt_cnt,
  output logic [S-1:0]   lbl_cnt,
  output logic [2*K-1:0] mask,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [1:0]     fsm_state
);

  // Beats are presented one per cycle with no back-pressure: any non-zero tag
  // in a cycle is a valid beat and is always consumed on that rising edge.
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_t;

  localparam logic [S-1:0] one_s = {{(S-1){1'b0}}, 1'b1};

  state_t         state, state_nx;
  logic [K-1:0]   r_nx, key_nx;
  logic           kv_nx, done_nx, err_nx;
  logic [1:0]     code_nx;
  logic           il_en0_nx, il_en1_nx, gt_en_nx;
  logic [S-1:0]   il_addr0_nx, il_addr1_nx, gt_addr0_nx, gt_addr1_nx;
  logic [K-1:0]   il_data0_nx, il_data1_nx, gt_data0_nx, gt_data1_nx;
  logic [S-1:0]   gt_cnt_nx, lbl_cnt_nx;
  logic [2*K-1:0] mask_nx, mask_cat;
  logic           err_hit;
  logic [1:0]     err_val;

  assign fsm_state = state;
  assign mask_cat  = {data0, data1};

  always_comb begin
    state_nx    = state;
    r_nx        = R;
    key_nx      = aes_key;
    kv_nx       = keys_valid;
    done_nx     = done;
    err_nx      = err;
    code_nx     = err_code;
    il_en0_nx   = 1'b0;
    il_en1_nx   = 1'b0;
    gt_en_nx    = 1'b0;
    il_addr0_nx = il_wr_addr0;
    il_addr1_nx = il_wr_addr1;
    il_data0_nx = il_wr_data0;
    il_data1_nx = il_wr_data1;
    gt_addr0_nx = gt_wr_addr0;
    gt_addr1_nx = gt_wr_addr1;
    gt_data0_nx = gt_wr_data0;
    gt_data1_nx = gt_wr_data1;
    gt_cnt_nx   = gt_cnt;
    lbl_cnt_nx  = lbl_cnt;
    mask_nx     = mask;
    err_hit     = 1'b0;
    err_val     = 2'b00;

    case (state)
      IDLE: begin
        case (tag)
          3'b000: ;
          3'b001: begin
            // R is a free-XOR offset whose LSB must be set.
            if (data0[0]) begin
              r_nx     = data0;
              key_nx   = data1;
              kv_nx    = 1'b1;
              state_nx = RECV;
            end else begin
              err_hit = 1'b1;
              err_val = 2'b01;
            end
          end
          3'b100:  begin err_hit = 1'b1; err_val = 2'b11; end
          default: begin err_hit = 1'b1; err_val = 2'b01; end
        endcase
      end
      RECV: begin
        case (tag)
          3'b000: ;
          3'b001: begin err_hit = 1'b1; err_val = 2'b01; end
          3'b010: begin
            if ((index0 == {gt_cnt[S-2:0], 1'b0}) && (index1 == index0 + one_s)) begin
              gt_en_nx    = 1'b1;
              gt_addr0_nx = index0;
              gt_addr1_nx = index1;
              gt_data0_nx = data0;
              gt_data1_nx = data1;
              gt_cnt_nx   = gt_cnt + one_s;
            end else begin
              err_hit = 1'b1;
              err_val = 2'b10;
            end
          end
          3'b011: begin
            for (int i = 0; i < 2*K; i++) mask_nx[i] = mask_cat[2*K-1-i];
            done_nx  = 1'b1;
            state_nx = DONE;
          end
          3'b100: begin err_hit = 1'b1; err_val = 2'b11; end
          default: begin
            if (tag[0]) begin
              il_en0_nx   = 1'b1;
              il_addr0_nx = index0;
              il_data0_nx = data0;
            end
            if (tag[1]) begin
              il_en1_nx   = 1'b1;
              il_addr1_nx = index1;
              il_data1_nx = data1;
            end
            lbl_cnt_nx = lbl_cnt + {{(S-1){1'b0}}, tag[0]} + {{(S-1){1'b0}}, tag[1]};
          end
        endcase
      end
      DONE: begin
        case (tag)
          3'b000, 3'b011: ;
          3'b100:  begin err_hit = 1'b1; err_val = 2'b11; end
          default: begin err_hit = 1'b1; err_val = 2'b01; end
        endcase
      end
      default: ;
    endcase

    if (err_hit) begin
      state_nx = ERROR;
      err_nx   = 1'b1;
      code_nx  = err_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      R           <= '0;
      aes_key     <= '0;
      keys_valid  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      il_wr_en0   <= 1'b0;
      il_wr_en1   <= 1'b0;
      gt_wr_en    <= 1'b0;
      il_wr_addr0 <= '0;
      il_wr_addr1 <= '0;
      il_wr_data0 <= '0;
      il_wr_data1 <= '0;
      gt_wr_addr0 <= '0;
      gt_wr_addr1 <= '0;
      gt_wr_data0 <= '0;
      gt_wr_data1 <= '0;
      gt_cnt      <= '0;
      lbl_cnt     <= '0;
      mask        <= '0;
    end else begin
      state       <= state_nx;
      R           <= r_nx;
      aes_key     <= key_nx;
      keys_valid  <= kv_nx;
      done        <= done_nx;
      err         <= err_nx;
      err_code    <= code_nx;
      il_wr_en0   <= il_en0_nx;
      il_wr_en1   <= il_en1_nx;
      gt_wr_en    <= gt_en_nx;
      il_wr_addr0 <= il_addr0_nx;
      il_wr_addr1 <= il_addr1_nx;
      il_wr_data0 <= il_data0_nx;
      il_wr_data1 <= il_data1_nx;
      gt_wr_addr0 <= gt_addr0_nx;
      gt_wr_addr1 <= gt_addr1_nx;
      gt_wr_data0 <= gt_data0_nx;
      gt_wr_data1 <= gt_data1_nx;
      gt_cnt      <= gt_cnt_nx;
      lbl_cnt     <= lbl_cnt_nx;
      mask        <= mask_nx;
    end
  end

endmodule
